// File: rtl/rr_lock_arbiter.sv
// Round-robin memory-lock arbiter: one owner at a time, rotating priority,
// optional hold-time limit with forced revoke and a one-cycle cooldown between grants.
module rr_lock_arbiter #(
    parameter int NUM_CORES  = 4,
    parameter int HOLD_LIMIT = 255,
    parameter int CNT_W      = 8,
    localparam int IDX_W     = $clog2(NUM_CORES)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_CORES-1:0] req,
    input  logic                 enable,
    output logic [NUM_CORES-1:0] grant,
    output logic                 locked,
    output logic [IDX_W-1:0]     owner,
    output logic [CNT_W-1:0]     hold_cnt,
    output logic                 timeout_pulse,
    output logic [7:0]           timeout_count
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_COOL  = 2'd2;

    localparam int PAD_W = 1 << IDX_W;
    localparam logic [IDX_W:0]     NUM_W    = (IDX_W+1)'(NUM_CORES);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_CORES - 1);
    localparam logic [IDX_W-1:0]   IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0]   IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]   CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]   LIMIT_M1 = CNT_W'(HOLD_LIMIT - 1);
    localparam bit                 TIMEOUT_EN = (HOLD_LIMIT != 0);
    localparam logic [NUM_CORES-1:0] GRANT_NONE = {NUM_CORES{1'b0}};
    localparam logic [NUM_CORES-1:0] GRANT_ONE  = {{(NUM_CORES-1){1'b0}}, 1'b1};
    localparam logic [7:0]         TC_MAX   = 8'hFF;
    localparam logic [7:0]         TC_ONE   = 8'h01;

    logic [1:0]           state_r, state_n;
    logic [NUM_CORES-1:0] grant_r, grant_n;
    logic                 locked_r, locked_n;
    logic [IDX_W-1:0]     owner_r, owner_n;
    logic [IDX_W-1:0]     ptr_r, ptr_n;
    logic [CNT_W-1:0]     hold_r, hold_n;
    logic                 pulse_r, pulse_n;
    logic [7:0]           tcount_r, tcount_n;

    logic [PAD_W-1:0]     req_pad_s;
    logic                 found_s;
    logic [IDX_W-1:0]     pick_s;
    logic                 owner_req_s;
    logic [IDX_W-1:0]     ptr_after_owner_s;

    // Zero-extend requests to a power-of-two width so every index code reads a defined bit
    always_comb begin
        req_pad_s                  = {PAD_W{1'b0}};
        req_pad_s[NUM_CORES-1:0]   = req;
    end

    // Rotating priority search: first requester at or above ptr, wrapping to core 0
    always_comb begin
        logic [IDX_W:0] sum_v;
        sum_v   = {(IDX_W+1){1'b0}};
        found_s = 1'b0;
        pick_s  = IDX_ZERO;
        for (int i = 0; i < NUM_CORES; i++) begin
            sum_v = {1'b0, ptr_r} + i[IDX_W:0];
            if (sum_v >= NUM_W) begin
                sum_v = sum_v - NUM_W;
            end else begin
                sum_v = sum_v;
            end
            if (!found_s && req_pad_s[sum_v[IDX_W-1:0]]) begin
                found_s = 1'b1;
                pick_s  = sum_v[IDX_W-1:0];
            end else begin
                found_s = found_s;
            end
        end
    end

    // Owner still requesting, and the pointer position just past the owner
    always_comb begin
        owner_req_s = |(req & grant_r);
        if (owner_r == LAST_IDX) begin
            ptr_after_owner_s = IDX_ZERO;
        end else begin
            ptr_after_owner_s = owner_r + IDX_ONE;
        end
    end

    // Next-state and next-output computation
    always_comb begin
        state_n  = state_r;
        grant_n  = grant_r;
        locked_n = locked_r;
        owner_n  = owner_r;
        ptr_n    = ptr_r;
        hold_n   = hold_r;
        pulse_n  = 1'b0;
        tcount_n = tcount_r;
        case (state_r)
            ST_IDLE: begin
                if (enable && found_s) begin
                    state_n  = ST_GRANT;
                    grant_n  = GRANT_ONE << pick_s;
                    locked_n = 1'b1;
                    owner_n  = pick_s;
                    hold_n   = CNT_ZERO;
                end else begin
                    state_n  = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (hold_r != CNT_MAX) begin
                    hold_n = hold_r + CNT_ONE;
                end else begin
                    hold_n = hold_r;
                end
                // A voluntary release takes precedence over the hold limit
                if (!owner_req_s) begin
                    state_n  = ST_COOL;
                    grant_n  = GRANT_NONE;
                    locked_n = 1'b0;
                    ptr_n    = ptr_after_owner_s;
                end else if (TIMEOUT_EN && (hold_r == LIMIT_M1)) begin
                    state_n  = ST_COOL;
                    grant_n  = GRANT_NONE;
                    locked_n = 1'b0;
                    ptr_n    = ptr_after_owner_s;
                    pulse_n  = 1'b1;
                    if (tcount_r != TC_MAX) begin
                        tcount_n = tcount_r + TC_ONE;
                    end else begin
                        tcount_n = tcount_r;
                    end
                end else begin
                    state_n  = ST_GRANT;
                end
            end
            ST_COOL: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n  = ST_IDLE;
                grant_n  = GRANT_NONE;
                locked_n = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            grant_r  <= GRANT_NONE;
            locked_r <= 1'b0;
            owner_r  <= IDX_ZERO;
            ptr_r    <= IDX_ZERO;
            hold_r   <= CNT_ZERO;
            pulse_r  <= 1'b0;
            tcount_r <= 8'h00;
        end else begin
            state_r  <= state_n;
            grant_r  <= grant_n;
            locked_r <= locked_n;
            owner_r  <= owner_n;
            ptr_r    <= ptr_n;
            hold_r   <= hold_n;
            pulse_r  <= pulse_n;
            tcount_r <= tcount_n;
        end
    end

    assign grant         = grant_r;
    assign locked        = locked_r;
    assign owner         = owner_r;
    assign hold_cnt      = hold_r;
    assign timeout_pulse = pulse_r;
    assign timeout_count = tcount_r;

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Self-checking bench for rr_lock_arbiter: directed scenarios plus random traffic
// compared against a cycle-level behavioural model of the arbitration rules.
module tb_rr_lock_arbiter;

    localparam int N   = 4;
    localparam int LIM = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req, reqb;
    logic       enable, enb;

    logic [3:0] grant_a, grant_b;
    logic       locked_a, locked_b;
    logic [1:0] owner_a, owner_b;
    logic [7:0] hold_a, hold_b;
    logic       pulse_a, pulse_b;
    logic [7:0] tcount_a, tcount_b;

    rr_lock_arbiter #(.NUM_CORES(N), .HOLD_LIMIT(LIM), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .req(req), .enable(enable),
        .grant(grant_a), .locked(locked_a), .owner(owner_a), .hold_cnt(hold_a),
        .timeout_pulse(pulse_a), .timeout_count(tcount_a)
    );

    rr_lock_arbiter #(.NUM_CORES(N), .HOLD_LIMIT(0), .CNT_W(8)) dut_b (
        .clk(clk), .rst(rst), .req(reqb), .enable(enb),
        .grant(grant_b), .locked(locked_b), .owner(owner_b), .hold_cnt(hold_b),
        .timeout_pulse(pulse_b), .timeout_count(tcount_b)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: who holds the lock, for how long, and how many idle cycles remain
    bit m_has;
    bit m_pulse;
    int m_owner, m_ptr, m_elapsed, m_gap, m_tcount;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_has = 1'b0; m_pulse = 1'b0;
        m_owner = 0; m_ptr = 0; m_elapsed = 0; m_gap = 0; m_tcount = 0;
    endtask

    task automatic model_edge();
        m_pulse = 1'b0;
        if (m_has) begin
            bit still = req[m_owner];
            bit lasted = (LIM != 0) && (m_elapsed + 1 == LIM);
            m_elapsed = (m_elapsed < 255) ? m_elapsed + 1 : 255;
            if (!still || lasted) begin
                m_has = 1'b0;
                m_ptr = (m_owner + 1) % N;
                m_gap = 1;
                if (still) begin
                    m_pulse  = 1'b1;
                    m_tcount = (m_tcount < 255) ? m_tcount + 1 : 255;
                end
            end
        end else if (m_gap > 0) begin
            m_gap--;
        end else if (enable && req != 4'b0000) begin
            for (int k = 0; k < N; k++) begin
                if (req[(m_ptr + k) % N]) begin
                    m_owner = (m_ptr + k) % N;
                    break;
                end
            end
            m_has = 1'b1;
            m_elapsed = 0;
        end
    endtask

    task automatic check_a();
        chk("grant",  32'(grant_a),  32'(m_has ? (1 << m_owner) : 0));
        chk("locked", 32'(locked_a), 32'(m_has));
        chk("owner",  32'(owner_a),  32'(m_owner));
        chk("hold",   32'(hold_a),   32'(m_elapsed));
        chk("pulse",  32'(pulse_a),  32'(m_pulse));
        chk("tcount", 32'(tcount_a), 32'(m_tcount));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_a();
    endtask

    initial begin
        rst = 1'b1; req = 4'b0000; reqb = 4'b0000; enable = 1'b1; enb = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_grant_a", 32'(grant_a), 32'h0);
        chk("rst_locked_a", 32'(locked_a), 32'h0);
        chk("rst_owner_a", 32'(owner_a), 32'h0);
        chk("rst_hold_a", 32'(hold_a), 32'h0);
        chk("rst_pulse_a", 32'(pulse_a), 32'h0);
        chk("rst_tcount_a", 32'(tcount_a), 32'h0);
        chk("rst_grant_b", 32'(grant_b), 32'h0);
        rst = 1'b0;

        // Single requester, release and immediate re-request
        req = 4'b0010; tick();
        chk("r030_grant", 32'(grant_a), 32'h2);
        chk("r030_owner", 32'(owner_a), 32'h1);
        req = 4'b0000; tick();
        chk("r030_drop", 32'(grant_a), 32'h0);
        req = 4'b0010; tick();
        chk("r030_gap", 32'(grant_a), 32'h0);
        tick();
        chk("r030_regrant", 32'(grant_a), 32'h2);

        // Core 1 releases -> pointer at 2, so core 3 wins over core 0
        req = 4'b0000; tick();
        req = 4'b1011; tick(); tick();
        chk("r032_ptr_order", 32'(grant_a), 32'h8);
        req = 4'b0000; repeat (3) tick();

        // Enable gating of new grants only
        enable = 1'b0; req = 4'b0100;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("r033_disabled", 32'(grant_a), 32'h0);
        end
        enable = 1'b1; tick();
        chk("r033_enabled", 32'(grant_a), 32'h4);
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("r033_held", 32'(grant_a), 32'h4);
        end
        req = 4'b0000; enable = 1'b1; repeat (3) tick();

        // Asynchronous reset in the middle of a grant
        req = 4'b0100; tick();
        chk("r029_pre", 32'(grant_a), 32'h4);
        rst = 1'b1;
        #2;
        chk("r029_grant", 32'(grant_a), 32'h0);
        chk("r029_locked", 32'(locked_a), 32'h0);
        chk("r029_owner", 32'(owner_a), 32'h0);
        chk("r029_tcount", 32'(tcount_a), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0; req = 4'b0000;
        model_reset();

        // All cores requesting: 8-cycle grants, 2-cycle gaps, rotating from core 0
        req = 4'b1111;
        for (int g = 0; g < 4; g++) begin
            for (int c = 0; c < LIM; c++) begin
                tick();
                chk("r031_grant", 32'(grant_a), 32'(1 << g));
            end
            tick();
            chk("r031_gap1", 32'(grant_a), 32'h0);
            chk("r031_pulse", 32'(pulse_a), 32'h1);
            chk("r031_count", 32'(tcount_a), 32'(g + 1));
            tick();
            chk("r031_gap2", 32'(grant_a), 32'h0);
            chk("r031_pulse_end", 32'(pulse_a), 32'h0);
        end
        tick();
        chk("r031_wrap", 32'(grant_a), 32'h1);
        chk("r031_tcount", 32'(tcount_a), 32'h4);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            enable = ($urandom_range(0, 7) != 0);
            tick();
        end
        req = 4'b0000; enable = 1'b1; repeat (4) tick();

        // No hold limit: grant persists, counter saturates, no revoke
        reqb = 4'b0001;
        for (int k = 0; k < 300; k++) begin
            tick();
            chk("r034_grant", 32'(grant_b), 32'h1);
            chk("r034_hold", 32'(hold_b), 32'((k < 255) ? k : 255));
            chk("r034_pulse", 32'(pulse_b), 32'h0);
        end
        chk("r034_tcount", 32'(tcount_b), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
